// File: rtl/core_pkg.sv
// Shared definitions for the core controller: instruction field positions,
// the idle instruction word, the controller state set and memory base addresses.
package core_pkg;

    localparam int INST_W       = 34;
    localparam int ADDR_W       = 11;

    localparam int ACC_BIT      = 33;
    localparam int CEN_PMEM_BIT = 32;
    localparam int WEN_PMEM_BIT = 31;
    localparam int A_PMEM_MSB   = 30;
    localparam int A_PMEM_LSB   = 20;
    localparam int CEN_XMEM_BIT = 19;
    localparam int WEN_XMEM_BIT = 18;
    localparam int A_XMEM_MSB   = 17;
    localparam int A_XMEM_LSB   = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    // Both memories deselected with writes disabled (active-low enables high).
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    localparam logic [ADDR_W-1:0] WEIGHT_BASE = 11'h400;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_XLOAD = 4'd1,
        S_WLOAD = 4'd2,
        S_L0W   = 4'd3,
        S_KLOAD = 4'd4,
        S_GAP   = 4'd5,
        S_L0X   = 4'd6,
        S_EXEC  = 4'd7,
        S_DRAIN = 4'd8,
        S_DONE  = 4'd9
    } state_e;

endpackage

// File: rtl/core_ctrl_inst_encode.sv
// Packs the individual control fields into the 34-bit core instruction word.
module inst_encode
    import core_pkg::*;
(
    input  logic              acc_i,
    input  logic              cen_pmem_i,
    input  logic              wen_pmem_i,
    input  logic [ADDR_W-1:0] a_pmem_i,
    input  logic              cen_xmem_i,
    input  logic              wen_xmem_i,
    input  logic [ADDR_W-1:0] a_xmem_i,
    input  logic              ofifo_rd_i,
    input  logic              ififo_wr_i,
    input  logic              ififo_rd_i,
    input  logic              l0_rd_i,
    input  logic              l0_wr_i,
    input  logic              execute_i,
    input  logic              load_i,
    output logic [INST_W-1:0] inst_o
);

    always_comb begin
        inst_o                          = '0;
        inst_o[ACC_BIT]                 = acc_i;
        inst_o[CEN_PMEM_BIT]            = cen_pmem_i;
        inst_o[WEN_PMEM_BIT]            = wen_pmem_i;
        inst_o[A_PMEM_MSB:A_PMEM_LSB]   = a_pmem_i;
        inst_o[CEN_XMEM_BIT]            = cen_xmem_i;
        inst_o[WEN_XMEM_BIT]            = wen_xmem_i;
        inst_o[A_XMEM_MSB:A_XMEM_LSB]   = a_xmem_i;
        inst_o[OFIFO_RD_BIT]            = ofifo_rd_i;
        inst_o[IFIFO_WR_BIT]            = ififo_wr_i;
        inst_o[IFIFO_RD_BIT]            = ififo_rd_i;
        inst_o[L0_RD_BIT]               = l0_rd_i;
        inst_o[L0_WR_BIT]               = l0_wr_i;
        inst_o[EXECUTE_BIT]             = execute_i;
        inst_o[LOAD_BIT]                = load_i;
    end

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer for the systolic core: streams activations and per-kernel weights
// into xmem, drives L0/array phases and drains the output FIFO into pmem.
//
// state | meaning
// IDLE  | waiting for start
// XLOAD | write len_nij activation words from the input stream into xmem
// WLOAD | write col weight words for kernel kij into xmem
// L0W   | copy the kernel's weights from xmem into L0
// KLOAD | load weights from L0 into the array
// GAP   | idle spacing before the activation pass
// L0X   | copy activations from xmem into L0
// EXEC  | stream activations through the array
// DRAIN | move len_nij output words from the FIFO into pmem
// DONE  | one-cycle completion pulse
module core_ctrl
    import core_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 16,
    parameter int row     = 16,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int gap     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   din_valid,
    input  logic [bw*row-1:0]      din_data,
    output logic                   din_ready,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] sfp_out,
    output logic [INST_W-1:0]      inst,
    output logic [bw*row-1:0]      D_xmem,
    output logic                   res_valid,
    output logic [col*psum_bw-1:0] res_data,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(col);
    localparam logic [ADDR_W-1:0] NIJ_A    = ADDR_W'(len_nij);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(col - 1);
    localparam logic [ADDR_W-1:0] NIJ_LAST = ADDR_W'(len_nij - 1);
    localparam logic [ADDR_W-1:0] GAP_LAST = ADDR_W'(gap - 1);
    localparam logic [ADDR_W-1:0] KIJ_LAST = ADDR_W'(len_kij - 1);

    if ((len_kij * len_nij > 1024) || (32'h400 + len_kij * col > 2048)) begin : g_bad_params
        $error("core_ctrl: parameter set overflows the 11-bit memory address space");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   kij_q, kij_d;
    logic                res_valid_q;
    logic [col*psum_bw-1:0] res_data_q;

    logic                cen_pmem, wen_pmem, cen_xmem, wen_xmem;
    logic                ofifo_rd, l0_rd, l0_wr, execute, load;
    logic [ADDR_W-1:0]   a_pmem, a_xmem;
    logic [ADDR_W-1:0]   w_addr, p_addr;

    // Address sums wrap naturally at 11 bits.
    assign w_addr = WEIGHT_BASE + kij_q * COL_A + cnt_q;
    assign p_addr = kij_q * NIJ_A + cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            kij_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kij_q       <= kij_d;
            res_valid_q <= ofifo_rd;
            if (ofifo_rd) begin
                res_data_q <= sfp_out;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kij_d     = kij_q;
        cen_pmem  = 1'b1;
        wen_pmem  = 1'b1;
        a_pmem    = '0;
        cen_xmem  = 1'b1;
        wen_xmem  = 1'b1;
        a_xmem    = '0;
        ofifo_rd  = 1'b0;
        l0_rd     = 1'b0;
        l0_wr     = 1'b0;
        execute   = 1'b0;
        load      = 1'b0;
        D_xmem    = '0;
        din_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_XLOAD;
                    cnt_d   = '0;
                    kij_d   = '0;
                end
            end
            S_XLOAD: begin
                din_ready = 1'b1;
                a_xmem    = cnt_q;
                if (din_valid) begin
                    cen_xmem = 1'b0;
                    wen_xmem = 1'b0;
                    D_xmem   = din_data;
                    if (cnt_q == NIJ_LAST) begin
                        state_d = S_WLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WLOAD: begin
                din_ready = 1'b1;
                a_xmem    = w_addr;
                if (din_valid) begin
                    cen_xmem = 1'b0;
                    wen_xmem = 1'b0;
                    D_xmem   = din_data;
                    if (cnt_q == COL_LAST) begin
                        state_d = S_L0W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_L0W: begin
                cen_xmem = 1'b0;
                a_xmem   = w_addr;
                l0_wr    = 1'b1;
                if (cnt_q == COL_LAST) begin
                    state_d = S_KLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_KLOAD: begin
                load  = 1'b1;
                l0_rd = 1'b1;
                if (cnt_q == COL_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_L0X;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_L0X: begin
                cen_xmem = 1'b0;
                a_xmem   = cnt_q;
                l0_wr    = 1'b1;
                if (cnt_q == NIJ_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                execute = 1'b1;
                l0_rd   = 1'b1;
                if (cnt_q == NIJ_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    cen_pmem = 1'b0;
                    wen_pmem = 1'b0;
                    a_pmem   = p_addr;
                    if (cnt_q == NIJ_LAST) begin
                        cnt_d = '0;
                        if (kij_q < KIJ_LAST) begin
                            kij_d   = kij_q + 1'b1;
                            state_d = S_WLOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    inst_encode u_inst_encode (
        .acc_i      (1'b0),
        .cen_pmem_i (cen_pmem),
        .wen_pmem_i (wen_pmem),
        .a_pmem_i   (a_pmem),
        .cen_xmem_i (cen_xmem),
        .wen_xmem_i (wen_xmem),
        .a_xmem_i   (a_xmem),
        .ofifo_rd_i (ofifo_rd),
        .ififo_wr_i (1'b0),
        .ififo_rd_i (1'b0),
        .l0_rd_i    (l0_rd),
        .l0_wr_i    (l0_wr),
        .execute_i  (execute),
        .load_i     (load),
        .inst_o     (inst)
    );

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a run-position model (one step counter per run)
// predicts every output each cycle under randomized stream/FIFO handshakes.
module tb_core_ctrl;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int COL     = 16;
    localparam int ROW     = 16;
    localparam int LEN_KIJ = 9;
    localparam int LEN_NIJ = 36;
    localparam int GAP     = 8;
    localparam int KBLK    = 3 * COL + GAP + 3 * LEN_NIJ;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic                   din_valid;
    logic [BW*ROW-1:0]      din_data;
    logic                   din_ready;
    logic                   ofifo_valid;
    logic [COL*PSUM_BW-1:0] sfp_out;
    logic [33:0]            inst;
    logic [BW*ROW-1:0]      D_xmem;
    logic                   res_valid;
    logic [COL*PSUM_BW-1:0] res_data;
    logic                   busy;
    logic                   done;

    core_ctrl #(
        .bw(BW), .psum_bw(PSUM_BW), .col(COL), .row(ROW),
        .len_kij(LEN_KIJ), .len_nij(LEN_NIJ), .gap(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
        .ofifo_valid(ofifo_valid), .sfp_out(sfp_out),
        .inst(inst), .D_xmem(D_xmem),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    // Model: a run is a fixed list of productive steps; m_n is how many have completed.
    bit                     m_active = 1'b0;
    int                     m_n      = 0;
    bit                     m_rv     = 1'b0;
    logic [COL*PSUM_BW-1:0] m_rd     = '0;

    logic [10:0] xw_addr[$];
    logic [10:0] pw_addr[$];
    int done_cnt, busy_cyc, xload_cyc;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic locate(input int n, output int ph, output int k, output int c);
        int r;
        k = 0;
        c = 0;
        if (n < LEN_NIJ) begin
            ph = 0; c = n;
        end else if (n < LEN_NIJ + LEN_KIJ * KBLK) begin
            r = n - LEN_NIJ;
            k = r / KBLK;
            r = r % KBLK;
            if (r < COL)                              begin ph = 1; c = r; end
            else if (r < 2 * COL)                     begin ph = 2; c = r - COL; end
            else if (r < 3 * COL)                     begin ph = 3; c = r - 2 * COL; end
            else if (r < 3 * COL + GAP)               begin ph = 4; c = r - 3 * COL; end
            else if (r < 3 * COL + GAP + LEN_NIJ)     begin ph = 5; c = r - (3 * COL + GAP); end
            else if (r < 3 * COL + GAP + 2 * LEN_NIJ) begin ph = 6; c = r - (3 * COL + GAP + LEN_NIJ); end
            else begin ph = 7; c = r - (3 * COL + GAP + 2 * LEN_NIJ); end
        end else begin
            ph = 8;
        end
    endtask

    task automatic expect_now(output logic [33:0] e_inst, output logic [63:0] e_d,
                              output logic e_ready, output logic e_busy, output logic e_done);
        int ph, k, c;
        logic cenp, wenp, cenx, wenx, ofrd, l0rd, l0wr, ex, ld;
        logic [10:0] ap, ax;
        cenp = 1; wenp = 1; cenx = 1; wenx = 1;
        ofrd = 0; l0rd = 0; l0wr = 0; ex = 0; ld = 0;
        ap = '0; ax = '0;
        e_d = '0; e_ready = 0; e_busy = m_active; e_done = 0;
        if (m_active) begin
            locate(m_n, ph, k, c);
            case (ph)
                0: begin
                    e_ready = 1; ax = 11'(c);
                    if (din_valid) begin cenx = 0; wenx = 0; e_d = din_data; end
                end
                1: begin
                    e_ready = 1; ax = 11'(1024 + k * COL + c);
                    if (din_valid) begin cenx = 0; wenx = 0; e_d = din_data; end
                end
                2: begin cenx = 0; ax = 11'(1024 + k * COL + c); l0wr = 1; end
                3: begin ld = 1; l0rd = 1; end
                4: begin end
                5: begin cenx = 0; ax = 11'(c); l0wr = 1; end
                6: begin ex = 1; l0rd = 1; end
                7: if (ofifo_valid) begin ofrd = 1; cenp = 0; wenp = 0; ap = 11'(k * LEN_NIJ + c); end
                default: e_done = 1;
            endcase
        end
        e_inst = {1'b0, cenp, wenp, ap, cenx, wenx, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic [33:0] e_inst;
        logic [63:0] e_d;
        logic e_ready, e_busy, e_done;
        int ph, k, c;
        bit prod;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_active = 0; m_rv = 0; m_rd = '0;
            end
            expect_now(e_inst, e_d, e_ready, e_busy, e_done);
            check("inst", inst, e_inst);
            check("D_xmem", D_xmem, e_d);
            check("din_ready", din_ready, e_ready);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("res_valid", res_valid, m_rv);
            check("res_data", res_data, m_rd);
            if (reset) begin
                if (!inst[19] && !inst[18]) xw_addr.push_back(inst[17:7]);
                if (!inst[32] && !inst[31]) pw_addr.push_back(inst[30:20]);
                if (done) done_cnt++;
                if (busy) busy_cyc++;
                if (din_ready && inst[17:7] < 11'h400) xload_cyc++;
            end
            @(posedge clk);
            if (!reset) begin
                m_active = 0; m_rv = 0; m_rd = '0;
            end else begin
                expect_now(e_inst, e_d, e_ready, e_busy, e_done);
                m_rv = e_inst[6];
                if (e_inst[6]) m_rd = sfp_out;
                if (m_active) begin
                    locate(m_n, ph, k, c);
                    prod = (ph == 0 || ph == 1) ? din_valid : (ph == 7) ? ofifo_valid : 1'b1;
                    if (prod) begin
                        if (ph == 8) m_active = 0;
                        else m_n++;
                    end
                end else if (start) begin
                    m_active = 1; m_n = 0;
                end
            end
        end
    end

    initial begin
        din_data = '0;
        sfp_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            din_data = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) sfp_out[i*32 +: 32] = $urandom;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        xw_addr.delete();
        pw_addr.delete();
        done_cnt = 0; busy_cyc = 0; xload_cyc = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    // mode 0: XLOAD stall at cnt 10 + random FIFO; 1: all valid + start during GAP;
    // 2: fully random handshakes with a reset during EXEC of kernel 2 (once).
    task automatic run_loop(input int mode, input string tag, input bit do_reset);
        int guard = 0;
        int ph, k, c;
        int stalls = 0;
        bit rst_done = 0;
        while (m_active && guard < 8000) begin
            locate(m_n, ph, k, c);
            start = 0;
            case (mode)
                0: begin
                    din_valid   = !(ph == 0 && c == 10 && stalls < 3);
                    ofifo_valid = 1'($urandom_range(0, 1));
                end
                1: begin
                    din_valid = 1; ofifo_valid = 1;
                    if (ph == 4 && k == 0 && c == 3) start = 1;
                end
                default: begin
                    din_valid   = 1'($urandom_range(0, 1));
                    ofifo_valid = 1'($urandom_range(0, 1));
                end
            endcase
            if (mode == 0 && !din_valid) begin
                stalls++;
                #1;
                check("stall_a_xmem", inst[17:7], 10);
                check("stall_cen_xmem", inst[19], 1);
            end
            if (do_reset && !rst_done && ph == 6 && k == 2 && c == 5) begin
                rst_done = 1;
                #1 reset = 0;
                #1;
                check("async_rst_inst", inst, IDLE_W);
                check("async_rst_busy", busy, 0);
                repeat (2) @(posedge clk);
                #1 reset = 1;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, "_finished"}, m_active, 0);
    endtask

    initial begin
        reset = 0; start = 0; din_valid = 0; ofifo_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", inst, IDLE_W);
        check("rst_busy", busy, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_D_xmem", D_xmem, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_done", done, 0);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        clear_stats();
        pulse_start();
        run_loop(0, "runA", 0);
        check("runA_xload_cycles", xload_cyc, 39);
        check("runA_xmem_writes", xw_addr.size(), 36 + LEN_KIJ * COL);
        if (xw_addr.size() >= 52) begin
            check("runA_xaddr35", xw_addr[35], 35);
            check("runA_waddr_first", xw_addr[36], 11'h400);
            check("runA_waddr_16th", xw_addr[51], 11'h40F);
        end
        check("runA_pmem_writes", pw_addr.size(), 324);
        if (pw_addr.size() >= 324) begin
            check("runA_paddr36", pw_addr[36], 36);
            check("runA_paddr71", pw_addr[71], 71);
            check("runA_paddr_last", pw_addr[323], 323);
        end
        check("runA_done_pulses", done_cnt, 1);
        check("runA_end_inst", inst, IDLE_W);
        repeat (3) @(posedge clk);
        #1;

        clear_stats();
        pulse_start();
        run_loop(1, "runB", 0);
        check("runB_busy_cycles", busy_cyc, 1513);
        check("runB_pmem_writes", pw_addr.size(), 324);
        check("runB_done_pulses", done_cnt, 1);
        check("runB_end_busy", busy, 0);
        check("runB_end_inst", inst, IDLE_W);
        repeat (2) @(posedge clk);
        #1;

        clear_stats();
        pulse_start();
        run_loop(2, "runC1", 1);
        repeat (3) @(posedge clk);
        #1;
        check("runC1_no_done", done_cnt, 0);
        check("runC1_idle_busy", busy, 0);

        clear_stats();
        start = 1;
        @(posedge clk);
        #1 start = 0;
        din_valid = 1;
        #1;
        check("restart_a_xmem", inst[17:7], 0);
        check("restart_wen_xmem", inst[18], 0);
        check("restart_din_ready", din_ready, 1);
        run_loop(2, "runC2", 0);
        check("runC2_pmem_writes", pw_addr.size(), 324);
        check("runC2_done_pulses", done_cnt, 1);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameters SHALL be: bw 4 (activation/weight bits); psum_bw 16 (partial-sum bits); col 16 (array columns); row 16 (array rows); len_kij 9 (kernel positions); len_nij 36 (output pixels); gap 8 (idle cycles between kernel load and activation load).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a full layer
- din_valid  in  1  input stream word valid
- din_data  in  bw*row  activation/weight word
- din_ready  out  1  stream word accepted this cycle
- ofifo_valid  in  1  core output FIFO non-empty
- sfp_out  in  col*psum_bw  core output data
- inst  out  34  core instruction word
- D_xmem  out  bw*row  activation/weight memory write data
- res_valid  out  1  result word valid
- res_data  out  col*psum_bw  result word
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse

Function
REQ-003 inst fields SHALL be: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load. CEN and WEN are active-low.
REQ-004 IDLE_INST SHALL be all zeros except bits 32, 31, 19 and 18, which are 1.
REQ-005 Registered state SHALL be: FSM state, step counter cnt, kernel index kij. inst, D_xmem and din_ready SHALL be combinational decodes of registered state, din_valid and ofifo_valid. Any field not listed for a state SHALL take its IDLE_INST value.
REQ-006 FSM states SHALL be IDLE, XLOAD, WLOAD, L0W, KLOAD, GAP, L0X, EXEC, DRAIN, DONE.
REQ-007 IDLE: inst = IDLE_INST; busy = 0. start = 1 → XLOAD with cnt = 0, kij = 0. start is ignored in every other state.
REQ-008 XLOAD: din_ready = 1.
- When din_valid = 1: CEN_xmem = 0, WEN_xmem = 0, A_xmem = cnt, D_xmem = din_data, cnt increments.
- When din_valid = 0: CEN_xmem = 1 and cnt holds.
- After accept number len_nij-1: → WLOAD, cnt = 0.
REQ-009 WLOAD: same handshake as XLOAD, with A_xmem = 0x400 + kij*col + cnt. Runs col accepts, then → L0W.
REQ-010 L0W: CEN_xmem = 0, WEN_xmem = 1, A_xmem = 0x400 + kij*col + cnt, l0_wr = 1. Runs col cycles, then → KLOAD.
REQ-011 KLOAD: load = 1, l0_rd = 1 for col cycles → GAP.
REQ-012 GAP: IDLE_INST for gap cycles → L0X.
REQ-013 L0X: CEN_xmem = 0, WEN_xmem = 1, A_xmem = cnt, l0_wr = 1 for len_nij cycles → EXEC.
REQ-014 EXEC: execute = 1, l0_rd = 1 for len_nij cycles → DRAIN.
REQ-015 DRAIN:
- When ofifo_valid = 1: ofifo_rd = 1, CEN_pmem = 0, WEN_pmem = 0, A_pmem = kij*len_nij + cnt, cnt increments.
- When ofifo_valid = 0: all of those fields idle and cnt holds.
- After len_nij reads: if kij < len_kij-1, kij increments and → WLOAD; otherwise → DONE.
REQ-016 DONE: done = 1 for exactly one cycle → IDLE.
REQ-017 Every cnt transition between states SHALL reset cnt to 0.
REQ-018 One cycle after each cycle with ofifo_rd = 1, res_valid SHALL be 1 and res_data SHALL hold the sfp_out value sampled on that ofifo_rd edge. Otherwise res_valid = 0.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Address arithmetic SHALL be unsigned and truncated to 11 bits. Parameter sets with len_kij*len_nij > 1024 or 0x400 + len_kij*col > 2048 are unsupported; a simulation-only check SHALL flag them.

Reset
REQ-021 reset = 0 SHALL immediately, without waiting for clk, force: state IDLE, cnt 0, kij 0, res_valid 0, res_data 0, done 0. The outputs then decode to inst = IDLE_INST, busy = 0, din_ready = 0, D_xmem = 0.
REQ-022 Reset asserted mid-run SHALL abandon the run with no done pulse. After release, only a new start begins a run.

Structure
REQ-023 A shared package core_pkg SHALL hold: the inst bit-position constants, IDLE_INST, the state enumeration, and the 0x400 weight base address.
REQ-024 One sub-module, inst_encode, SHALL pack the field values into the 34-bit inst word. The FSM SHALL stay in core_ctrl.

Verification
REQ-025 Reset, start pulse, din_valid held 1 → 36 xmem writes at A_xmem 0..35, then 16 writes at 0x400..0x40F, with D_xmem equal to din_data each cycle.
REQ-026 din_valid = 0 for 3 cycles at XLOAD cnt = 10 → CEN_xmem = 1 and A_xmem held at 10 for those cycles; XLOAD lasts 39 cycles total.
REQ-027 ofifo_valid toggling during DRAIN at kij = 1 → ofifo_rd and pmem write only when ofifo_valid = 1. A_pmem runs 36..71. res_valid follows each read by one cycle with matching data.
REQ-028 Full run with ofifo_valid = 1 and din_valid = 1 → 324 pmem writes, exactly one done pulse, then busy = 0 and inst = IDLE_INST.
REQ-029 reset = 0 during EXEC → inst = IDLE_INST before the next clk edge, with no done pulse. start after release → run restarts in XLOAD at A_xmem 0.
REQ-030 start pulsed during GAP → ignored: state sequence and cycle counts unchanged.
